// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - states, opcodes and select encodings for the multi-cycle controller.
// MC_JAL_EN adds the JAL state to the state enum.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
`ifdef MC_JAL_EN
    S_BRANCH,
    S_JAL
`else
    S_BRANCH
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ImmSrc is decoded from op alone, independent of state and of MC_JAL_EN.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath signal bundle.
// master = controller (drives selects/enables), slave = datapath.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Sign;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, Sign, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Sign, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - combinational ALUOp/funct decode to ALUControl.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       alu_illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    alu_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with funct7b5 subtracts; addi ignores instr[30].
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencer for the multi-cycle RV32I datapath.
// MC_JAL_EN enables the JAL state; without it opcode 1101111 is flagged illegal.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  logic       pc_update, branch, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       decode_illegal, exec_state;
  logic       taken, branch_bad;
  logic [2:0] alu_control;
  logic       alu_illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (alu_control),
    .alu_illegal (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pc_update      = 1'b0;
    branch         = 1'b0;
    adr_src        = 1'b0;
    ir_write       = 1'b0;
    mem_write      = 1'b0;
    reg_write      = 1'b0;
    result_src     = RES_ALUOUT;
    alu_src_a      = SRCA_PC;
    alu_src_b      = SRCB_RS2;
    alu_op         = ALUOP_ADD;
    decode_illegal = 1'b0;
    exec_state     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for a later branch or jump.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef MC_JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default: begin
            state_d        = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        exec_state = 1'b1;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        exec_state = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    taken      = 1'b0;
    branch_bad = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = ~bus.Zero;
      3'b100:  taken = bus.Sign;
      default: branch_bad = 1'b1;
    endcase
  end

  // Reset forces every output low so no write escapes an abandoned instruction.
  assign bus.PCWrite    = ~rst & (pc_update | (branch & taken));
  assign bus.AdrSrc     = ~rst & adr_src;
  assign bus.IRWrite    = ~rst & ir_write;
  assign bus.MemWrite   = ~rst & mem_write;
  assign bus.RegWrite   = ~rst & reg_write;
  assign bus.ResultSrc  = rst ? 2'b00 : result_src;
  assign bus.ALUSrcA    = rst ? 2'b00 : alu_src_a;
  assign bus.ALUSrcB    = rst ? 2'b00 : alu_src_b;
  assign bus.ImmSrc     = rst ? 2'b00 : imm_src_of(bus.op);
  assign bus.ALUControl = rst ? 3'b000 : alu_control;
  assign bus.illegal    = ~rst & (decode_illegal | (exec_state & alu_illegal) | (branch & branch_bad));

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - per-cycle model check of multicycle_controller (honours MC_JAL_EN).
module tb_multicycle_controller;

`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  typedef struct {
    logic       rst, ready;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, s;
    exp_t       e;
    int         seg;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

  rec_t       q[$];
  int         n_checks = 0, n_fail = 0;
  string      seg_name[64];
  int         nseg = 0;
  int         irw_cnt[64], memw_cnt[64], regw_cnt[64], pcw_cnt[64], ill_cnt[64];
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic       c_f7, c_z, c_s;
  int         c_seg, c_n;

  task automatic check(string name, int got, int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic logic [1:0] imm_m(logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] alu_m(logic [2:0] f3, logic f7, logic op5);
    case (f3)
      3'b000:  return (f7 && op5) ? 3'b010 : 3'b000;
      3'b001:  return 3'b001;
      3'b100:  return 3'b100;
      3'b101:  return 3'b101;
      3'b110:  return 3'b110;
      3'b111:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken_m(logic [2:0] f3, logic z, logic s);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t base();
    exp_t e = '0;
    e.imm = imm_m(c_op);
    return e;
  endfunction

  task automatic push(logic r, logic rdy, exp_t e);
    rec_t x;
    x.rst = r; x.ready = rdy; x.op = c_op; x.f3 = c_f3; x.f7 = c_f7;
    x.z = c_z; x.s = c_s; x.e = e; x.seg = c_seg;
    q.push_back(x);
    c_n++;
  endtask

  task automatic new_seg(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic s);
    seg_name[nseg] = name;
    c_seg = nseg;
    nseg++;
    c_op = op; c_f3 = f3; c_f7 = f7; c_z = z; c_s = s; c_n = 0;
  endtask

  // Expected cycle-by-cycle outputs of one instruction; fw/mw are wait cycles in fetch/memory.
  task automatic instr(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic s,
                       int fw, int mw, bit abort, output int n, output int seg);
    exp_t e;
    bit   legal;
    new_seg(name, op, f3, f7, z, s);
    seg = c_seg;
    e = base(); e.b = 2'b10; e.res = 2'b10;
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, e);
    e.irw = 1'b1; e.pcw = 1'b1;
    push(1'b0, 1'b1, e);
    legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
            (op == 7'b0010011) || (op == 7'b1100011) || (JAL_EN && op == 7'b1101111);
    e = base(); e.a = 2'b01; e.b = 2'b01; e.ill = !legal;
    push(1'b0, 1'b1, e);
    if (legal) begin
      if (op == 7'b0000011 || op == 7'b0100011) begin
        e = base(); e.a = 2'b10; e.b = 2'b01;
        push(1'b0, 1'b1, e);
        if (abort) begin
          push(1'b1, 1'b0, '0);
        end else if (op == 7'b0000011) begin
          e = base(); e.adr = 1'b1;
          for (int i = 0; i < mw; i++) push(1'b0, 1'b0, e);
          push(1'b0, 1'b1, e);
          e = base(); e.res = 2'b01; e.regw = 1'b1;
          push(1'b0, 1'b1, e);
        end else begin
          e = base(); e.adr = 1'b1; e.memw = 1'b1;
          for (int i = 0; i < mw; i++) push(1'b0, 1'b0, e);
          push(1'b0, 1'b1, e);
        end
      end else if (op == 7'b0110011 || op == 7'b0010011) begin
        e = base(); e.a = 2'b10; e.b = (op == 7'b0110011) ? 2'b00 : 2'b01;
        e.alu = alu_m(f3, f7, op[5]); e.ill = (f3 == 3'b010) || (f3 == 3'b011);
        push(1'b0, 1'b1, e);
        e = base(); e.regw = 1'b1;
        push(1'b0, 1'b1, e);
      end else if (op == 7'b1100011) begin
        e = base(); e.a = 2'b10; e.alu = 3'b010; e.pcw = taken_m(f3, z, s);
        e.ill = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100);
        push(1'b0, 1'b1, e);
      end else begin
        e = base(); e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1;
        push(1'b0, 1'b1, e);
        e = base(); e.regw = 1'b1;
        push(1'b0, 1'b1, e);
      end
    end
    n = c_n;
  endtask

  initial begin
    exp_t got;
    int n, s_lw, s_sw, s_add, s_addi, s_beq, s_bne, s_blt, s_b110, s_lui, s_jal, s_abort, s_dummy;
    int n_lw, n_sw, n_add, n_addi, n_beq, n_lui, n_jal;

    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.Sign = 1'b0; bus.mem_ready = 1'b0;

    new_seg("reset", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, '0);
    push(1'b1, 1'b0, '0);
    instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n_lw, s_lw);
    instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0, n_sw, s_sw);
    instr("add",    7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, n_add, s_add);
    instr("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, n, s_dummy);
    instr("addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, n_addi, s_addi);
    instr("slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n, s_dummy);
    instr("srai",   7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, n, s_dummy);
    instr("xor",    7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n, s_dummy);
    instr("and",    7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n, s_dummy);
    instr("beq",    7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, n_beq, s_beq);
    instr("bne",    7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, n, s_bne);
    instr("blt",    7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, n, s_blt);
    instr("b110",   7'b1100011, 3'b110, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, n, s_b110);
    instr("lui",    7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n_lui, s_lui);
    instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n_jal, s_jal);
    instr("lw_wait",7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1, 2, 1'b0, n, s_dummy);
    instr("sw_rst", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, n, s_abort);
    instr("add2",   7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n, s_dummy);

    foreach (q[i]) begin
      @(negedge clk);
      rst = q[i].rst; bus.mem_ready = q[i].ready; bus.op = q[i].op;
      bus.funct3 = q[i].f3; bus.funct7b5 = q[i].f7; bus.Zero = q[i].z; bus.Sign = q[i].s;
      #2;
      got = {bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.illegal};
      n_checks++;
      if (got !== q[i].e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs got %h, expected %h", seg_name[q[i].seg], i, got, q[i].e);
      end
      irw_cnt[q[i].seg]  += int'(got.irw);
      memw_cnt[q[i].seg] += int'(got.memw);
      regw_cnt[q[i].seg] += int'(got.regw);
      pcw_cnt[q[i].seg]  += int'(got.pcw);
      ill_cnt[q[i].seg]  += int'(got.ill);
    end

    check("lw_cycles", n_lw, 5);
    check("sw_wait_cycles", n_sw, 6);
    check("add_fetchwait_cycles", n_add, 5);
    check("addi_cycles", n_addi, 4);
    check("beq_cycles", n_beq, 3);
    check("lui_cycles", n_lui, 2);
    check("jal_cycles", n_jal, JAL_EN ? 4 : 2);
    check("model_sub", int'(alu_m(3'b000, 1'b1, 1'b1)), 2);
    check("model_addi_f7", int'(alu_m(3'b000, 1'b1, 1'b0)), 0);
    check("lw_regwrite", regw_cnt[s_lw], 1);
    check("sw_irwrite", irw_cnt[s_sw], 1);
    check("sw_memwrite", memw_cnt[s_sw], 3);
    check("beq_pcwrite", pcw_cnt[s_beq], 2);
    check("bne_pcwrite", pcw_cnt[s_bne], 1);
    check("blt_pcwrite", pcw_cnt[s_blt], 2);
    check("b110_illegal", ill_cnt[s_b110], 1);
    check("b110_pcwrite", pcw_cnt[s_b110], 1);
    check("lui_illegal", ill_cnt[s_lui], 1);
    check("jal_pcwrite", pcw_cnt[s_jal], JAL_EN ? 2 : 1);
    check("abort_memwrite", memw_cnt[s_abort], 0);
    check("abort_regwrite", regw_cnt[s_abort], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I datapath: one shared ALU, one unified instruction/data memory port, and the IR/OldPC/Data/ALUOut holding registers. A Moore state machine plus one Mealy term steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable in that datapath. It replaces the purely combinational decode used by the single-cycle core, and stalls on a memory ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0], taken from IR.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU result == 0.
- Sign  in  1  ALU result[31].
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  load PC.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- MemWrite  out  1  memory store strobe.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
- illegal  out  1  one-cycle pulse when an instruction is unsupported.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.

FETCH
- Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- While mem_ready=1: IRWrite=1 and PCUpdate=1, and the next state is DECODE.
- While mem_ready=0: the controller holds in FETCH with IRWrite=0 and PCUpdate=0.

DECODE
- Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00; this precomputes the branch/jump target into ALUOut.
- Next state by op:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL (only when the macro is defined).
  - Any other op → FETCH, with illegal=1.

Per-state actions
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. MemWrite stays high until mem_ready is sampled high; next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.

Decode rules
- PCWrite = PCUpdate | (Branch & taken). This is the only Mealy output.
- Branch condition `taken`:
  - funct3 000: taken = Zero.
  - funct3 001: taken = ~Zero.
  - funct3 100: taken = Sign.
  - Any other funct3: taken = 0, and illegal pulses in BRANCH.
- ImmSrc is decoded combinationally from op in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, otherwise 00.
- ALUControl:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 → by funct3:
    - 000: sub when {funct7b5, op[5]} = 11, else add.
    - 001 sll, 100 xor, 101 srl, 110 or, 111 and.
    - 010, 011: illegal pulses in EXEC* and ALUControl = add.
    - srai (101 with funct7b5=1) executes as srl; it is not flagged.
- Every output not listed for a state is 0 in that state. Don't-cares (x) are never driven.

## Timing
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, I-type ALU 4, branch 3, jal 4.
- Each cycle in which mem_ready is low during FETCH, MEMREAD or MEMWRITE adds exactly one cycle; all outputs are held stable while waiting.
- Reset: with rst high at a clock edge, the state becomes FETCH. While rst is high, all outputs are forced to 0, including IRWrite, PCWrite and MemWrite.
- Reset mid-instruction abandons the instruction; no partial write is issued after the reset edge.
- FETCH is entered on the first cycle after rst deasserts.
- Every state and output is stable from clock edge to clock edge, except PCWrite, which follows Zero/Sign combinationally in BRANCH.

## Configuration
- MC_JAL_EN defined: the JAL state exists, and opcode 1101111 takes the path DECODE → JAL → ALUWB. rd receives PC+4 and the PC loads the target.
- MC_JAL_EN undefined: the JAL state is absent. Opcode 1101111 takes the illegal path (illegal pulse in DECODE, return to FETCH). ImmSrc=11 is still decoded.

## Structure
- Shared package holds:
  - the state enum;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - the ALUControl encodings and the ALUOp/ResultSrc/ALUSrc select encodings.
- Sub-module alu_decoder: combinational, {ALUOp, funct3, funct7b5, op5} → {ALUControl, alu_illegal}.
- Top level: the state register plus output/next-state decode.

## Test plan
- Reset, then lw (op 0000011) with mem_ready=1: states are FETCH→DECODE→MEMADR→MEMREAD→MEMWB across 5 cycles. RegWrite=1 only in cycle 5, with ResultSrc=01.
- sw with mem_ready low for 2 cycles in MEMWRITE: MemWrite stays high for 3 cycles, total 6 cycles. IRWrite pulses exactly once.
- add vs sub: funct3=000, op=0110011, funct7b5=0 → ALUControl=000 in EXECR; with funct7b5=1 → 010. addi with funct7b5=1 → 000.
- beq with Zero=1 → PCWrite=1 in BRANCH. bne with Zero=1 → PCWrite=0. blt with Sign=1 → PCWrite=1. funct3=110 → illegal=1, PCWrite=0.
- Opcode 0110111 → illegal=1 in DECODE and back to FETCH in cycle 3. With MC_JAL_EN defined, op 1101111 → JAL then ALUWB, with PCWrite=1 in JAL.
- rst asserted during MEMWRITE → MemWrite=0 in that cycle and FETCH on the next cycle; no RegWrite occurs.
